// File: rtl/pipe_stage_skid.sv
// Pipeline register with valid/ready handshake, a one-entry skid buffer and synchronous flush.
// Defining PIPE_STAGE_PERF_EN adds a saturating stall counter on stall_cnt_o.
module pipe_stage_skid #(
  parameter int unsigned      WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int unsigned      CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             up_valid_i,
  output logic             up_ready_o,
  input  logic [WIDTH-1:0] up_data_i,
  output logic             dn_valid_o,
  input  logic             dn_ready_i,
  output logic [WIDTH-1:0] dn_data_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] main_data_r;
  logic [WIDTH-1:0] skid_data_r;
  logic             dn_valid_r;
  logic             up_ready_r;
  logic             acc_s;
  logic             pop_s;

  // Ready comes straight from a flop, so no path exists from dn_ready_i to up_ready_o.
  assign acc_s      = up_valid_i & up_ready_r;
  assign pop_s      = dn_valid_r & dn_ready_i;
  assign up_ready_o = up_ready_r;
  assign dn_valid_o = dn_valid_r;
  assign dn_data_o  = main_data_r;

  // Occupancy state machine with main/skid data and registered handshake outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= ST_EMPTY;
      main_data_r <= RESET_VAL;
      skid_data_r <= RESET_VAL;
      dn_valid_r  <= 1'b0;
      up_ready_r  <= 1'b1;
    end else if (flush_i) begin
      state_r     <= ST_EMPTY;
      main_data_r <= RESET_VAL;
      skid_data_r <= RESET_VAL;
      dn_valid_r  <= 1'b0;
      up_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (acc_s) begin
            state_r     <= ST_ONE;
            main_data_r <= up_data_i;
            dn_valid_r  <= 1'b1;
            up_ready_r  <= 1'b1;
          end else begin
            state_r     <= ST_EMPTY;
            dn_valid_r  <= 1'b0;
            up_ready_r  <= 1'b1;
          end
        end
        ST_ONE: begin
          if (acc_s && pop_s) begin
            main_data_r <= up_data_i;
          end else if (acc_s) begin
            // Downstream stalled: park the new word behind the head.
            state_r     <= ST_TWO;
            skid_data_r <= up_data_i;
            up_ready_r  <= 1'b0;
          end else if (pop_s) begin
            state_r     <= ST_EMPTY;
            dn_valid_r  <= 1'b0;
          end else begin
            state_r     <= ST_ONE;
          end
        end
        ST_TWO: begin
          if (pop_s) begin
            state_r     <= ST_ONE;
            main_data_r <= skid_data_r;
            up_ready_r  <= 1'b1;
          end else begin
            state_r     <= ST_TWO;
          end
        end
        default: begin
          state_r     <= ST_EMPTY;
          main_data_r <= RESET_VAL;
          skid_data_r <= RESET_VAL;
          dn_valid_r  <= 1'b0;
          up_ready_r  <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_r;

  assign stall_cnt_o = stall_cnt_r;

  // Saturating count of cycles where a valid word is refused downstream; flush does not clear it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (dn_valid_r && !dn_ready_i && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end
`else
  logic [CNT_W-1:0] unused_stall_cnt_s;
  assign unused_stall_cnt_s = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomised self-checking bench for pipe_stage_skid against a small queue model.
// The perf-counter scenario runs only when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_skid;

  localparam int unsigned W     = 16;
  localparam int unsigned CW    = 4;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          up_valid;
  logic          up_ready;
  logic [W-1:0]  up_data;
  logic          dn_valid;
  logic          dn_ready;
  logic [W-1:0]  dn_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_skid #(
    .WIDTH     (W),
    .RESET_VAL ({W{1'b0}}),
    .CNT_W     (CW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .up_valid_i  (up_valid),
    .up_ready_o  (up_ready),
    .up_data_i   (up_data),
    .dn_valid_o  (dn_valid),
    .dn_ready_i  (dn_ready),
    .dn_data_o   (dn_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; up_valid = 1'b0; up_data = 16'h0000; dn_ready = 1'b0;
    #1;
    n_checks++; if (dn_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dn_valid got %0b want 0", dn_valid); end
    n_checks++; if (up_ready !== 1'b1) begin n_fail++; $display("FAIL reset_up_ready got %0b want 1", up_ready); end
    n_checks++; if (dn_data !== 16'h0000) begin n_fail++; $display("FAIL reset_dn_data got %h want 0000", dn_data); end
    step();
    rst = 1'b0;
    // Fill to two entries, then hit reset between edges.
    up_valid = 1'b1; up_data = 16'h0055; step();
    up_data = 16'h0066; step();
    up_valid = 1'b0;
    n_checks++; if (up_ready !== 1'b0) begin n_fail++; $display("FAIL reset_pre_two got %0b want 0", up_ready); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (dn_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_dn_valid got %0b want 0", dn_valid); end
    n_checks++; if (up_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_up_ready got %0b want 1", up_ready); end
    n_checks++; if (dn_data !== 16'h0000) begin n_fail++; $display("FAIL midreset_dn_data got %h want 0000", dn_data); end
    #1 rst = 1'b0;
    step();
    n_checks++; if (dn_valid !== 1'b0) begin n_fail++; $display("FAIL postreset_dn_valid got %0b want 0", dn_valid); end
  endtask

  task automatic test_streaming();
    dn_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      up_valid = 1'b1; up_data = W'(i);
      n_checks++; if (up_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d] got %0b want 1", i, up_ready); end
      step();
      n_checks++; if (dn_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got %0b want 1", i, dn_valid); end
      n_checks++; if (dn_data !== W'(i)) begin n_fail++; $display("FAIL stream_data[%0d] got %h want %h", i, dn_data, W'(i)); end
    end
    up_valid = 1'b0;
    step();
    n_checks++; if (dn_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain got %0b want 0", dn_valid); end
  endtask

  task automatic test_backpressure();
    dn_ready = 1'b0;
    up_valid = 1'b1; up_data = 16'h000A; step();
    n_checks++; if (up_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready1 got %0b want 1", up_ready); end
    up_data = 16'h000B; step();
    n_checks++; if (up_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready2 got %0b want 0", up_ready); end
    n_checks++; if (dn_data !== 16'h000A) begin n_fail++; $display("FAIL bp_head got %h want 000a", dn_data); end
    up_data = 16'h000C;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++; if (dn_data !== 16'h000A) begin n_fail++; $display("FAIL bp_hold[%0d] got %h want 000a", k, dn_data); end
      n_checks++; if (up_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full[%0d] got %0b want 0", k, up_ready); end
    end
    dn_ready = 1'b1; step();
    n_checks++; if (dn_data !== 16'h000B) begin n_fail++; $display("FAIL bp_out_b got %h want 000b", dn_data); end
    n_checks++; if (up_ready !== 1'b1) begin n_fail++; $display("FAIL bp_reopen got %0b want 1", up_ready); end
    step();
    n_checks++; if (dn_data !== 16'h000C) begin n_fail++; $display("FAIL bp_out_c got %h want 000c", dn_data); end
    n_checks++; if (dn_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_c got %0b want 1", dn_valid); end
    up_valid = 1'b0; step();
    n_checks++; if (dn_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %0b want 0", dn_valid); end
  endtask

  task automatic test_flush();
    dn_ready = 1'b0;
    up_valid = 1'b1; up_data = 16'h0011; step();
    up_data = 16'h0022; step();
    up_data = 16'h0033; flush = 1'b1; step();
    flush = 1'b0; up_valid = 1'b0;
    n_checks++; if (dn_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %0b want 0", dn_valid); end
    n_checks++; if (dn_data !== 16'h0000) begin n_fail++; $display("FAIL flush_data got %h want 0000", dn_data); end
    n_checks++; if (up_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %0b want 1", up_ready); end
    dn_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++; if (dn_valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak[%0d] got %0b data %h want 0", k, dn_valid, dn_data); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] q[$];
    logic         m_acc, m_pop, rd0;
    for (int c = 0; c < 4000; c++) begin
      n_checks++; if (dn_valid !== (q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid[%0d] got %0b want %0b", c, dn_valid, q.size() > 0); end
      n_checks++; if (up_ready !== (q.size() < 2)) begin n_fail++; $display("FAIL rnd_ready[%0d] got %0b want %0b", c, up_ready, q.size() < 2); end
      if (q.size() > 0) begin
        n_checks++; if (dn_data !== q[0]) begin n_fail++; $display("FAIL rnd_data[%0d] got %h want %h", c, dn_data, q[0]); end
      end
      up_valid = ($urandom_range(3) != 0);
      up_data  = W'($urandom);
      flush    = ($urandom_range(99) == 0);
      rd0      = $urandom_range(1) == 1;
      dn_ready = ~rd0;
      #1;
      dn_ready = rd0;
      #1;
      n_checks++; if (up_ready !== (q.size() < 2)) begin n_fail++; $display("FAIL rnd_ready_comb[%0d] got %0b want %0b", c, up_ready, q.size() < 2); end
      m_acc = up_valid && (q.size() < 2);
      m_pop = dn_ready && (q.size() > 0);
      @(posedge clk);
      if (flush) begin
        q.delete();
      end else begin
        if (m_pop) void'(q.pop_front());
        if (m_acc) q.push_back(up_data);
      end
      #1;
    end
    flush = 1'b0; up_valid = 1'b0;
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    rst = 1'b1; #1; rst = 1'b0;
    n_checks++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL perf_init got %0d want 0", stall_cnt); end
    dn_ready = 1'b0; up_valid = 1'b1; up_data = 16'h0077; step();
    up_valid = 1'b0;
    for (int k = 0; k < 5; k++) step();
    n_checks++; if (stall_cnt !== 4'd5) begin n_fail++; $display("FAIL perf_count5 got %0d want 5", stall_cnt); end
    for (int k = 0; k < 15; k++) step();
    n_checks++; if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL perf_sat got %0d want 15", stall_cnt); end
    flush = 1'b1; step(); flush = 1'b0; step();
    n_checks++; if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL perf_flush got %0d want 15", stall_cnt); end
    rst = 1'b1; #1;
    n_checks++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL perf_reset got %0d want 0", stall_cnt); end
    rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_random();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
